// File: rtl/system_param_loader_master_if.sv
// system_param_loader_master_if: Avalon-MM master/slave bus between the parameter loader and the PIO interconnect
interface system_param_loader_master_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );
  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/system_param_loader_master.sv
// system_param_loader_master: pushes a parameter table to Avalon-MM PIO slaves, then optionally reads it back and compares
module system_param_loader_master #(
  parameter int                N_PARAMS    = 4,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STRIDE = 16,
  parameter bit                VERIFY      = 1'b1,
  parameter int                TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tbl_wr_en,
  input  logic [3:0]  tbl_wr_idx,
  input  logic [31:0] tbl_wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_mismatch,
  output logic        err_timeout,
  output logic [3:0]  err_idx,
  system_param_loader_master_if.master bus
);
  localparam int IW = N_PARAMS > 1 ? $clog2(N_PARAMS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD_CMD = 3'd2, RD_WAIT = 3'd3, FIN = 3'd4;
  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] err_idx_r;
  logic [CW-1:0] cnt;
  logic [31:0]   tbl [N_PARAMS];
  logic          cmd, accept, rsp, last, waiting, expire, mismatch, prior;
  assign cmd      = state == WR || state == RD_CMD;
  assign accept   = cmd && !bus.avm_waitrequest;
  // a read may be accepted and answered in the same cycle
  assign rsp      = bus.avm_readdatavalid && ((state == RD_CMD && accept) || state == RD_WAIT);
  assign last     = idx == IW'(N_PARAMS - 1);
  assign waiting  = cmd ? bus.avm_waitrequest : state == RD_WAIT && !bus.avm_readdatavalid;
  assign expire   = waiting && cnt == CW'(TIMEOUT - 1);
  assign mismatch = bus.avm_readdata != tbl[idx];
  assign prior    = err_mismatch || err_timeout;
  assign busy     = state inside {WR, RD_CMD, RD_WAIT};
  assign done     = state == FIN;
  assign err_idx  = 4'(err_idx_r);
  assign bus.avm_write     = state == WR;
  assign bus.avm_read      = state == RD_CMD;
  assign bus.avm_address   = cmd ? BASE_ADDR + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE) : '0;
  assign bus.avm_writedata = state == WR ? tbl[idx] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
      err_idx_r    <= '0;
      for (int i = 0; i < N_PARAMS; i++) tbl[i] <= '0;
    end else begin
      // table is frozen while a run is in progress
      if (tbl_wr_en && !busy && 32'(tbl_wr_idx) < N_PARAMS) tbl[tbl_wr_idx[IW-1:0]] <= tbl_wr_data;
      cnt <= waiting && !expire ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
          state        <= WR;
          idx          <= '0;
          err_mismatch <= 1'b0;
          err_timeout  <= 1'b0;
          err_idx_r    <= '0;
        end
        WR: if (accept) begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= VERIFY ? RD_CMD : FIN;
        end
        RD_CMD, RD_WAIT: if (rsp) begin
          idx   <= last ? '0 : idx + 1'b1;
          state <= last ? FIN : RD_CMD;
        end else if (accept) state <= RD_WAIT;
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rsp && mismatch) begin
        err_mismatch <= 1'b1;
        if (!prior) err_idx_r <= idx;
      end
      if (expire) begin
        err_timeout <= 1'b1;
        state       <= FIN;
        if (!prior) err_idx_r <= idx;
      end
    end
  end
endmodule

// File: tb/tb_system_param_loader_master.sv
// tb_system_param_loader_master: directed runs against a reactive Avalon slave model with per-cycle protocol/data checks
module tb_system_param_loader_master;
  logic clk = 1'b0, reset = 1'b1, tbl_wr_en = 1'b0, start = 1'b0;
  logic [3:0] tbl_wr_idx = '0;
  logic [31:0] tbl_wr_data = '0;
  logic busy, done, err_mismatch, err_timeout;
  logic [3:0] err_idx;
  system_param_loader_master_if #(.ADDR_W(16)) bus ();
  system_param_loader_master dut (
    .clk(clk), .reset(reset), .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_data(tbl_wr_data), .start(start), .busy(busy), .done(done),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .err_idx(err_idx), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {bit wr; int addr; int data; int cyc;} txn_t;
  txn_t lg[$];
  int vec = 0, errs = 0, cyc = 0, done_cnt = 0;
  int cmd_cyc [2][4];
  logic [31:0] mdl_tbl [4] = '{default: '0};
  logic [31:0] mem [4] = '{default: '0};
  int stall_idx = -1, stall_left = 0, corrupt_idx = -1, rd_lat = 0, rd_cnt = 0, rd_slot = 0, sl = 0;
  bit stuck = 0, stray = 0, rd_pend = 0;
  logic prev_cmd = 1'b0, p_wr = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_data = '0;
  int exp_addr [4] = '{0, 16, 32, 48};
  int exp_data [4] = '{255, 1000, 8, 3};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] resp(input int s);
    return s == corrupt_idx ? 32'd999 : mem[s];
  endfunction
  // slave: decides waitrequest/response for the coming edge from the command now on the bus
  always @(negedge clk) begin
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    if (reset) rd_pend = 0;
    else begin
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = resp(rd_slot);
          rd_pend = 0;
        end else rd_cnt--;
      end
      if (bus.avm_write || bus.avm_read) begin
        sl = int'(bus.avm_address[5:4]);
        if (stuck || (bus.avm_write && sl == stall_idx && stall_left > 0)) begin
          bus.avm_waitrequest = 1'b1;
          if (!stuck) stall_left--;
        end else if (bus.avm_write) begin
          mem[sl] = bus.avm_writedata;
          lg.push_back('{wr: 1'b1, addr: int'(bus.avm_address), data: int'(bus.avm_writedata), cyc: cyc});
          if (stray && sl == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = 32'hDEAD_BEEF;
          end
        end else begin
          lg.push_back('{wr: 1'b0, addr: int'(bus.avm_address), data: 0, cyc: cyc});
          if (rd_lat == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = resp(sl);
          end else begin
            rd_pend = 1;
            rd_cnt = rd_lat - 1;
            rd_slot = sl;
          end
        end
      end
    end
  end
  // compare process: every cycle out of reset
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      cyc++;
      chk("rw_exclusive", 32'(bus.avm_write & bus.avm_read), 0);
      if (bus.avm_write || bus.avm_read) begin
        chk("cmd_busy", 32'(busy), 1);
        chk("addr_map", 32'(bus.avm_address[3:0] == 4'd0 && bus.avm_address < 16'h40), 1);
        if (bus.avm_write) chk("wdata", bus.avm_writedata, mdl_tbl[bus.avm_address[5:4]]);
        if (prev_cmd && bus.avm_waitrequest) begin
          chk("held_addr", 32'(bus.avm_address), 32'(p_addr));
          chk("held_kind", 32'(bus.avm_write), 32'(p_wr));
          chk("held_data", bus.avm_writedata, p_data);
        end
        cmd_cyc[bus.avm_write ? 1 : 0][int'(bus.avm_address[5:4])]++;
      end
      if (done) begin
        done_cnt++;
        chk("done_not_busy", 32'(busy), 0);
      end
      prev_cmd = bus.avm_write | bus.avm_read;
      p_addr = bus.avm_address;
      p_wr = bus.avm_write;
      p_data = bus.avm_writedata;
    end else prev_cmd = 1'b0;
  end
  task automatic clr();
    lg.delete();
    done_cnt = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) cmd_cyc[i][j] = 0;
  endtask
  task automatic kick();
    clr();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic finish_run(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    chk("run_done", 32'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
  endtask
  task automatic set_tbl(input int i, input logic [31:0] d, input bit take);
    @(negedge clk); tbl_wr_en = 1'b1; tbl_wr_idx = 4'(i); tbl_wr_data = d;
    @(negedge clk); tbl_wr_en = 1'b0;
    if (take) mdl_tbl[i] = d;
  endtask
  task automatic chk_flags(input string nm, input logic mis, input logic tmo, input logic [3:0] ei);
    chk(nm, {26'b0, err_mismatch, err_timeout, err_idx}, {26'b0, mis, tmo, ei});
  endtask
  task automatic chk_reset_outs(input string nm);
    chk(nm, {25'b0, busy, done, err_mismatch, err_timeout, bus.avm_write, bus.avm_read, |err_idx}, 0);
    chk({nm, "_addr"}, 32'(bus.avm_address), 0);
    chk({nm, "_wdata"}, bus.avm_writedata, 0);
  endtask
  initial begin
    int n, w2;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset_state");
    reset = 1'b0;
    // T1: zero-wait slave, back-to-back writes then read/compare
    for (int i = 0; i < 4; i++) set_tbl(i, 32'(exp_data[i]), 1);
    kick();
    finish_run(100);
    chk("t1_len", 32'(lg.size()), 8);
    if (lg.size() == 8) for (int i = 0; i < 4; i++) begin
      chk("t1_waddr", 32'(lg[i].addr), 32'(exp_addr[i]));
      chk("t1_wdata", 32'(lg[i].data), 32'(exp_data[i]));
      chk("t1_back2back", 32'(lg[i].cyc - lg[0].cyc), 32'(i));
      chk("t1_rd_kind", 32'(lg[i+4].wr), 0);
      chk("t1_raddr", 32'(lg[i+4].addr), 32'(exp_addr[i]));
    end
    chk_flags("t1_flags", 0, 0, 0);
    // T2: 3-cycle stall on idx 2, one-cycle read latency, stray readdatavalid during a write
    stall_idx = 2; stall_left = 3; stray = 1; rd_lat = 1;
    kick();
    finish_run(100);
    chk("t2_stall_cycles", 32'(cmd_cyc[1][2]), 4);
    w2 = 0;
    foreach (lg[i]) if (lg[i].wr && lg[i].addr == 32) w2++;
    chk("t2_single_write", 32'(w2), 1);
    chk("t2_len", 32'(lg.size()), 8);
    chk_flags("t2_flags", 0, 0, 0);
    stall_idx = -1; stray = 0;
    // T3: corrupted readback of idx 1
    corrupt_idx = 1; rd_lat = 2;
    kick();
    finish_run(100);
    n = 0;
    foreach (lg[i]) if (!lg[i].wr) n++;
    chk("t3_reads", 32'(n), 4);
    chk_flags("t3_flags", 1, 0, 4'd1);
    corrupt_idx = -1; rd_lat = 0;
    // T4: waitrequest stuck high
    stuck = 1;
    kick();
    finish_run(400);
    chk("t4_write_cycles", 32'(cmd_cyc[1][0]), 255);
    chk("t4_no_accept", 32'(lg.size()), 0);
    chk("t4_cmd_dropped", 32'(bus.avm_write | bus.avm_read), 0);
    chk_flags("t4_flags", 0, 1, 0);
    stuck = 0;
    kick();
    finish_run(100);
    chk_flags("t4_cleared", 0, 0, 0);
    chk("t4_len", 32'(lg.size()), 8);
    // T5: table write coincident with start lands first; mid-run start/table write dropped
    clr();
    @(negedge clk); tbl_wr_en = 1'b1; tbl_wr_idx = 4'd3; tbl_wr_data = 32'd42; start = 1'b1;
    @(negedge clk); tbl_wr_en = 1'b0; start = 1'b0; mdl_tbl[3] = 32'd42;
    @(negedge clk); tbl_wr_en = 1'b1; tbl_wr_idx = 4'd0; tbl_wr_data = 32'd77; start = 1'b1;
    @(negedge clk); tbl_wr_en = 1'b0; start = 1'b0;
    finish_run(100);
    if (lg.size() == 8) begin
      chk("t5_new_value", 32'(lg[3].data), 42);
      chk("t5_frozen", 32'(lg[0].data), 255);
    end else chk("t5_len", 32'(lg.size()), 8);
    chk("t5_start_ignored", 32'(busy), 0);
    chk_flags("t5_flags", 0, 0, 0);
    kick();
    finish_run(100);
    if (lg.size() > 0) chk("t5_table_kept", 32'(lg[0].data), 255);
    else chk("t5_rerun_len", 32'(lg.size()), 8);
    // reset while waiting for read data
    rd_lat = 5;
    kick();
    n = 0;
    while (!bus.avm_read && n < 50) begin @(posedge clk); #1; n++; end
    chk("t5_reached_read", 32'(bus.avm_read), 1);
    @(posedge clk); #3;
    chk("t5_in_rdwait", 32'({busy, bus.avm_read}), 32'(2'b10));
    reset = 1'b1;
    #1;
    chk_reset_outs("t5_reset_outs");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    mdl_tbl = '{default: '0};
    repeat (10) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt), 0);
    chk_flags("t5_post_reset", 0, 0, 0);
    rd_lat = 1;
    kick();
    finish_run(100);
    chk_flags("t5_clean_run", 0, 0, 0);
    if (lg.size() > 0) chk("t5_table_zeroed", 32'(lg[0].data), 0);
    else chk("t5_clean_len", 32'(lg.size()), 8);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
